// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - pipeline hazard unit with long-op scoreboard and stall counter
module hazard_scoreboard_unit #(
  parameter int NUM_REGS     = 32,
  parameter int MAX_LONG     = 4,
  parameter int BRANCH_IN_ID = 1,
  parameter int WB_BYPASS    = 1,
  parameter int CNT_W        = 32,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_rs1,
  input  logic [AW-1:0]       id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_reg_write,
  input  logic                id_long_op,
  input  logic                id_branch,
  input  logic                id_jump,
  input  logic [AW-1:0]       ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic [AW-1:0]       mem_rd,
  input  logic                mem_mem_read,
  input  logic                pc_src,
  input  logic                wb_long_valid,
  input  logic [AW-1:0]       wb_long_rd,
  output logic                stall_if,
  output logic                stall_id,
  output logic                flush_id,
  output logic                flush_ex,
  output logic [NUM_REGS-1:0] sb_pending,
  output logic                long_busy,
  output logic [CNT_W-1:0]    stall_count
);

  localparam logic [3:0] MAX_L = 4'(MAX_LONG);
  localparam bit         BR_EN = (BRANCH_IN_ID != 0);
  localparam bit         BYP   = (WB_BYPASS != 0);

  logic [3:0]          outstanding;
  logic [NUM_REGS-1:0] sb_next;
  logic                q1, q2;
  logic                hit1_ex, hit2_ex, hit1_mem, hit2_mem;
  logic                load_use, br_alu, br_load, sb_raw1, sb_raw2;
  logic                sb_waw, struct_haz, data_haz, issue;

  // Operand-use qualification: unused or x0 source fields never match anything.
  assign q1       = id_valid && id_use_rs1 && (id_rs1 != '0);
  assign q2       = id_valid && id_use_rs2 && (id_rs2 != '0);
  assign hit1_ex  = q1 && (id_rs1 == ex_rd);
  assign hit2_ex  = q2 && (id_rs2 == ex_rd);
  assign hit1_mem = q1 && (id_rs1 == mem_rd);
  assign hit2_mem = q2 && (id_rs2 == mem_rd);

  assign load_use = ex_mem_read && (hit1_ex || hit2_ex);
  assign br_alu   = BR_EN && id_branch && ex_reg_write && !ex_mem_read && (hit1_ex || hit2_ex);
  assign br_load  = BR_EN && id_branch && mem_mem_read && (hit1_mem || hit2_mem);

  // A completing long op writes through the regfile, so its reader need not wait.
  assign sb_raw1  = q1 && sb_pending[id_rs1] && !(BYP && wb_long_valid && (wb_long_rd == id_rs1));
  assign sb_raw2  = q2 && sb_pending[id_rs2] && !(BYP && wb_long_valid && (wb_long_rd == id_rs2));

  assign sb_waw     = id_valid && id_reg_write && (id_rd != '0) && sb_pending[id_rd];
  assign struct_haz = id_valid && id_long_op && (outstanding == MAX_L);
  assign data_haz   = load_use || br_alu || br_load || sb_raw1 || sb_raw2 || sb_waw || struct_haz;
  assign issue      = id_valid && !pc_src && !data_haz && id_long_op;

  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (!rst) begin
      if (pc_src) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (data_haz) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end else if (id_jump && id_valid) begin
        flush_id = 1'b1;
      end
    end
  end

  // Set is applied after clear so a same-cycle reissue to the same register wins.
  always_comb begin
    sb_next = sb_pending;
    if (wb_long_valid && (wb_long_rd != '0)) sb_next[wb_long_rd] = 1'b0;
    if (issue && id_reg_write && (id_rd != '0)) sb_next[id_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_pending  <= '0;
      outstanding <= '0;
      stall_count <= '0;
    end else begin
      sb_pending <= sb_next;
      if (issue && !wb_long_valid) begin
        outstanding <= outstanding + 4'd1;
      end else if (!issue && wb_long_valid && (outstanding != '0)) begin
        outstanding <= outstanding - 4'd1;
      end
      if (stall_id && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  assign long_busy = (outstanding != '0);

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int ML = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_long_op, id_branch, id_jump;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_long_rd;
  logic ex_reg_write, ex_mem_read, mem_mem_read, pc_src, wb_long_valid;

  logic stall_if, stall_id, flush_id, flush_ex, long_busy;
  logic [NR-1:0] sb_pending;
  logic [CW-1:0] stall_count;

  logic nb_stall_if, nb_stall_id, nb_flush_id, nb_flush_ex, nb_long_busy;
  logic [NR-1:0] nb_sb_pending;
  logic [CW-1:0] nb_stall_count;

  int checks = 0;
  int errors = 0;

  bit [31:0] pend;
  int outst;
  int cnt;
  bit ready = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.NUM_REGS(NR), .MAX_LONG(ML), .BRANCH_IN_ID(1), .WB_BYPASS(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_long_op(id_long_op), .id_branch(id_branch), .id_jump(id_jump), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
    .mem_mem_read(mem_mem_read), .pc_src(pc_src), .wb_long_valid(wb_long_valid),
    .wb_long_rd(wb_long_rd), .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .flush_ex(flush_ex), .sb_pending(sb_pending), .long_busy(long_busy), .stall_count(stall_count)
  );

  hazard_scoreboard_unit #(.NUM_REGS(NR), .MAX_LONG(ML), .BRANCH_IN_ID(0), .WB_BYPASS(1), .CNT_W(CW)) dut_nb (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_long_op(id_long_op), .id_branch(id_branch), .id_jump(id_jump), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
    .mem_mem_read(mem_mem_read), .pc_src(pc_src), .wb_long_valid(wb_long_valid),
    .wb_long_rd(wb_long_rd), .stall_if(nb_stall_if), .stall_id(nb_stall_id), .flush_id(nb_flush_id),
    .flush_ex(nb_flush_ex), .sb_pending(nb_sb_pending), .long_busy(nb_long_busy),
    .stall_count(nb_stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {issue, stall_if, stall_id, flush_id, flush_ex} from the rules and model state.
  function automatic logic [4:0] model_eval();
    bit haz = 0;
    bit iss;
    for (int k = 0; k < 2; k++) begin
      int rs  = (k == 0) ? int'(id_rs1) : int'(id_rs2);
      bit use_ = (k == 0) ? id_use_rs1 : id_use_rs2;
      if (id_valid && use_ && rs != 0) begin
        if (ex_mem_read && rs == ex_rd) haz = 1;
        if (id_branch && ex_reg_write && !ex_mem_read && rs == ex_rd) haz = 1;
        if (id_branch && mem_mem_read && rs == mem_rd) haz = 1;
        if (pend[rs] && !(wb_long_valid && wb_long_rd == rs)) haz = 1;
      end
    end
    if (id_valid && id_reg_write && id_rd != 0 && pend[id_rd]) haz = 1;
    if (id_valid && id_long_op && outst == ML) haz = 1;
    iss = id_valid && !pc_src && !haz && id_long_op;
    if (rst) return 5'b0;
    if (pc_src) return {iss, 4'b0011};
    if (haz) return {iss, 4'b1101};
    if (id_jump && id_valid) return {iss, 4'b0010};
    return {iss, 4'b0000};
  endfunction

  always @(posedge clk) begin
    logic [4:0] e;
    if (rst) begin
      pend = 0; outst = 0; cnt = 0; ready = 1;
    end else if (ready) begin
      e = model_eval();
      if (e[2] && cnt < 7) cnt++;
      if (wb_long_valid && wb_long_rd != 0) pend[wb_long_rd] = 0;
      if (e[4] && id_reg_write && id_rd != 0) pend[id_rd] = 1;
      if (e[4] && !wb_long_valid) outst++;
      else if (!e[4] && wb_long_valid && outst > 0) outst--;
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (ready) begin
      e = model_eval();
      chk("m_stall_if", 32'(stall_if), 32'(e[3]));
      chk("m_stall_id", 32'(stall_id), 32'(e[2]));
      chk("m_flush_id", 32'(flush_id), 32'(e[1]));
      chk("m_flush_ex", 32'(flush_ex), 32'(e[0]));
      chk("m_sb_pending", sb_pending, pend);
      chk("m_long_busy", 32'(long_busy), 32'(outst != 0));
      chk("m_stall_count", 32'(stall_count), 32'(cnt));
    end
  end

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_long_op = 0;
    id_branch = 0; id_jump = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_rd = 0; mem_rd = 0;
    wb_long_rd = 0; ex_reg_write = 0; ex_mem_read = 0; mem_mem_read = 0; pc_src = 0;
    wb_long_valid = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic long_op(input int rd);
    id_valid = 1; id_long_op = 1; id_reg_write = 1; id_rd = AW'(rd);
  endtask

  task automatic wb(input int rd);
    wb_long_valid = 1; wb_long_rd = AW'(rd);
  endtask

  initial begin
    idle();
    rst = 1;
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; ex_mem_read = 1; ex_rd = 5;
    tick(); tick();
    @(negedge clk);
    chk("rst_stall_if", 32'(stall_if), 0);
    chk("rst_flush_ex", 32'(flush_ex), 0);
    chk("rst_sb_pending", sb_pending, 0);
    chk("rst_stall_count", 32'(stall_count), 0);
    tick(); rst = 0; idle();

    // Load-use on rs1
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; ex_mem_read = 1; ex_rd = 5;
    @(negedge clk);
    chk("lu_stall_if", 32'(stall_if), 1);
    chk("lu_stall_id", 32'(stall_id), 1);
    chk("lu_flush_ex", 32'(flush_ex), 1);
    tick(); idle();
    @(negedge clk);
    chk("lu_count", 32'(stall_count), 1);
    chk("lu_released", 32'(stall_id), 0);

    // x0 and unused operand never stall
    tick(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 0; ex_mem_read = 1; ex_rd = 0;
    @(negedge clk); chk("x0_nostall", 32'(stall_id), 0);
    tick(); idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 3; id_rs2 = 6; ex_mem_read = 1; ex_rd = 6;
    @(negedge clk); chk("unused_rs2_nostall", 32'(stall_id), 0);

    // Scoreboard RAW with write-through release
    tick(); idle(); long_op(7);
    tick(); idle();
    @(negedge clk);
    chk("div_pending", sb_pending, 32'h80);
    chk("div_busy", 32'(long_busy), 1);
    tick(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 7;
    @(negedge clk); chk("raw_stall1", 32'(stall_id), 1);
    tick();
    @(negedge clk); chk("raw_stall2", 32'(stall_id), 1);
    tick(); wb(7);
    @(negedge clk); chk("raw_bypass", 32'(stall_id), 0);
    tick(); idle();
    @(negedge clk);
    chk("raw_cleared", sb_pending, 0);
    chk("raw_idle", 32'(long_busy), 0);
    chk("raw_count", 32'(stall_count), 3);

    // Structural limit with two outstanding
    tick(); long_op(8);
    tick(); long_op(9);
    tick(); long_op(10);
    @(negedge clk); chk("struct_stall", 32'(stall_id), 1);
    tick(); wb(8);
    @(negedge clk); chk("struct_no_bypass", 32'(stall_id), 1);
    tick(); wb_long_valid = 0;
    @(negedge clk); chk("struct_issue", 32'(stall_id), 0);
    tick(); idle();
    @(negedge clk); chk("struct_pending", sb_pending, 32'h0000_0600);
    tick(); wb(9);
    tick(); wb(10);
    tick(); idle();
    @(negedge clk);
    chk("drain_busy", 32'(long_busy), 0);
    chk("struct_count", 32'(stall_count), 5);

    // Redirect beats load-use and blocks issue
    tick(); long_op(11); id_use_rs1 = 1; id_rs1 = 5; ex_mem_read = 1; ex_rd = 5; pc_src = 1;
    @(negedge clk);
    chk("pc_flush_id", 32'(flush_id), 1);
    chk("pc_flush_ex", 32'(flush_ex), 1);
    chk("pc_stall_if", 32'(stall_if), 0);
    tick(); idle();
    @(negedge clk);
    chk("pc_no_set", sb_pending, 0);
    chk("pc_count", 32'(stall_count), 5);

    // Branch operand hazards
    tick(); id_valid = 1; id_branch = 1; id_use_rs1 = 1; id_rs1 = 4; ex_reg_write = 1; ex_rd = 4;
    @(negedge clk);
    chk("br_alu_stall", 32'(stall_id), 1);
    chk("br_alu_off", 32'(nb_flush_ex), 0);
    tick(); idle(); id_valid = 1; id_branch = 1; id_use_rs2 = 1; id_rs2 = 12; mem_mem_read = 1; mem_rd = 12;
    @(negedge clk);
    chk("br_load_stall", 32'(stall_id), 1);
    chk("br_load_off", 32'(nb_stall_id), 0);
    tick(); idle();
    @(negedge clk); chk("br_count", 32'(stall_count), 7);

    // Saturation, jump flush, WAW
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; ex_mem_read = 1; ex_rd = 5;
    tick(); idle();
    @(negedge clk); chk("sat_count", 32'(stall_count), 7);
    tick(); id_valid = 1; id_jump = 1;
    @(negedge clk);
    chk("jump_flush_id", 32'(flush_id), 1);
    chk("jump_flush_ex", 32'(flush_ex), 0);
    tick(); idle(); long_op(13);
    tick(); idle(); id_valid = 1; id_reg_write = 1; id_rd = 13;
    @(negedge clk); chk("waw_stall", 32'(stall_id), 1);
    tick(); idle(); wb(13);
    tick(); idle();
    @(negedge clk); chk("waw_cleared", sb_pending, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
